// File: rtl/systolic_slave_ctrl_gen.sv
// systolic_slave_ctrl_gen: slave-side controller for one systolic array.
// Buffers spike packets, sequences a line, drains psums with bias add.
module systolic_slave_ctrl_gen #(
  parameter int DATA_WIDTH     = 64,
  parameter int UNIT_NUM       = 16,
  parameter int TIME_STEPS     = 4,
  parameter int LANE_WIDTH     = 20,
  parameter int BIAS_WIDTH     = 16,
  parameter int LINE_SLICES    = 24,
  parameter int OUT_TILES      = 24,
  parameter int W_BEATS        = 32,
  parameter int PKT_FIFO_DEPTH = 64,
  parameter int SATURATE       = 1
) (
  input  logic                                    s_clk,
  input  logic                                    s_rst,
  input  logic                                    i_mst_valid,
  input  logic [DATA_WIDTH-1:0]                   i_mst_data,
  input  logic                                    i_mst_done,
  output logic                                    o_mst_ready,
  input  logic [DATA_WIDTH-1:0]                   i_w_data,
  input  logic                                    i_w_avail,
  output logic                                    o_w_valid,
  output logic [DATA_WIDTH-1:0]                   o_w_data,
  output logic                                    o_w_done,
  input  logic                                    i_w_ready,
  output logic                                    o_a_valid,
  output logic [DATA_WIDTH-1:0]                   o_a_data,
  output logic                                    o_a_done,
  input  logic                                    i_a_ready,
  output logic                                    o_init,
  input  logic                                    i_calc_done,
  output logic [UNIT_NUM-1:0]                     o_grant,
  output logic                                    o_pop,
  input  logic [TIME_STEPS*LANE_WIDTH-1:0]        i_psum,
  output logic [$clog2(OUT_TILES*UNIT_NUM)-1:0]   o_bias_addr,
  input  logic [BIAS_WIDTH-1:0]                   i_bias,
  output logic                                    o_psum_valid,
  output logic [TIME_STEPS*LANE_WIDTH-1:0]        o_psum_data,
  input  logic                                    i_psum_ready,
  output logic                                    o_busy
);

  localparam int PW   = TIME_STEPS * LANE_WIDTH;
  localparam int AW   = $clog2(PKT_FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int NPOP = UNIT_NUM * UNIT_NUM;
  localparam int PCW  = $clog2(NPOP);
  localparam int SW   = (LINE_SLICES > 1) ? $clog2(LINE_SLICES) : 1;
  localparam int WW   = (W_BEATS > 1) ? $clog2(W_BEATS) : 1;
  localparam int TW   = (OUT_TILES > 1) ? $clog2(OUT_TILES) : 1;
  localparam int BAW  = $clog2(OUT_TILES * UNIT_NUM);
  localparam int EXT  = LANE_WIDTH + 1 - BIAS_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT, ST_LOAD, ST_WAIT_CALC, ST_FETCH, ST_DRAIN
  } state_t;

  state_t              state_q;
  logic [DATA_WIDTH:0] fifo_mem [PKT_FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       cnt_q, pkt_q;
  logic                err_ovf_q;
  logic [SW-1:0]       slice_q;
  logic [WW-1:0]       w_cnt_q;
  logic [UNIT_NUM-1:0] grant_q;
  logic [PCW-1:0]      pop_cnt_q;
  logic [TW-1:0]       tile_q;
  logic                v1_q;
  logic [PW-1:0]       ob_mem [4];
  logic [1:0]          ob_wr_q, ob_rd_q;
  logic [2:0]          ob_cnt_q;

  logic                fifo_full, fifo_empty, wr_en;
  logic [DATA_WIDTH:0] head;
  logic                a_xfer, a_done_xfer, pkt_inc;
  logic                pop_ok, ob_pop;
  logic [LANE_WIDTH:0] bias_ext, lane_s;
  logic [PW-1:0]       sum_word;

  assign fifo_full   = cnt_q == CW'(PKT_FIFO_DEPTH);
  assign fifo_empty  = cnt_q == '0;
  assign wr_en       = i_mst_valid & ~fifo_full;
  assign pkt_inc     = wr_en & i_mst_done;
  assign head        = fifo_mem[rd_ptr_q];
  assign o_mst_ready = cnt_q <= CW'(PKT_FIFO_DEPTH - 2);

  assign o_a_valid   = (state_q == ST_LOAD) & ~fifo_empty & (pkt_q != '0);
  assign o_a_data    = o_a_valid ? head[DATA_WIDTH-1:0] : '0;
  assign o_a_done    = o_a_valid & head[DATA_WIDTH];
  assign a_xfer      = o_a_valid & i_a_ready;
  assign a_done_xfer = a_xfer & head[DATA_WIDTH];

  assign o_w_valid   = i_w_avail & i_w_ready;
  assign o_w_data    = i_w_data;
  assign o_w_done    = o_w_valid & (w_cnt_q == WW'(W_BEATS - 1));

  assign o_init      = state_q == ST_INIT;
  assign o_busy      = state_q != ST_IDLE;
  assign o_grant     = grant_q;

  // Credit check: issued-but-unbuffered words plus buffered words fit in 4.
  assign pop_ok      = (state_q == ST_FETCH) & ((3'(v1_q) + ob_cnt_q) < 3'd4);
  assign o_pop       = pop_ok;
  assign o_bias_addr = (state_q == ST_FETCH)
                     ? BAW'(tile_q) * BAW'(UNIT_NUM) + BAW'(pop_cnt_q % UNIT_NUM)
                     : '0;

  assign o_psum_valid = ob_cnt_q != '0;
  assign o_psum_data  = o_psum_valid ? ob_mem[ob_rd_q] : '0;
  assign ob_pop       = o_psum_valid & i_psum_ready;

  assign bias_ext = {{EXT{i_bias[BIAS_WIDTH-1]}}, i_bias};

  always_comb begin
    sum_word = '0;
    lane_s   = '0;
    for (int l = 0; l < TIME_STEPS; l++) begin
      lane_s = {i_psum[l*LANE_WIDTH+LANE_WIDTH-1],
                i_psum[l*LANE_WIDTH +: LANE_WIDTH]} + bias_ext;
      if (SATURATE != 0 && lane_s[LANE_WIDTH] != lane_s[LANE_WIDTH-1])
        sum_word[l*LANE_WIDTH +: LANE_WIDTH] = lane_s[LANE_WIDTH]
          ? {1'b1, {(LANE_WIDTH-1){1'b0}}}
          : {1'b0, {(LANE_WIDTH-1){1'b1}}};
      else
        sum_word[l*LANE_WIDTH +: LANE_WIDTH] = lane_s[LANE_WIDTH-1:0];
    end
  end

  always_ff @(posedge s_clk) begin
    if (wr_en) fifo_mem[wr_ptr_q] <= {i_mst_done, i_mst_data};
    if (v1_q)  ob_mem[ob_wr_q]    <= sum_word;
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      pkt_q     <= '0;
      err_ovf_q <= 1'b0;
      w_cnt_q   <= '0;
      v1_q      <= 1'b0;
      ob_wr_q   <= '0;
      ob_rd_q   <= '0;
      ob_cnt_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (i_mst_valid & fifo_full) err_ovf_q <= 1'b1;
      if (a_xfer) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(wr_en) - CW'(a_xfer);
      pkt_q <= pkt_q + CW'(pkt_inc) - CW'(a_done_xfer);
      if (o_w_valid)
        w_cnt_q <= o_w_done ? '0 : w_cnt_q + 1'b1;
      v1_q <= pop_ok;
      if (v1_q)   ob_wr_q <= ob_wr_q + 1'b1;
      if (ob_pop) ob_rd_q <= ob_rd_q + 1'b1;
      ob_cnt_q <= ob_cnt_q + 3'(v1_q) - 3'(ob_pop);
    end
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state_q   <= ST_IDLE;
      slice_q   <= '0;
      grant_q   <= '0;
      pop_cnt_q <= '0;
      tile_q    <= '0;
    end else begin
      if (pop_ok) begin
        grant_q   <= {grant_q[UNIT_NUM-2:0], grant_q[UNIT_NUM-1]};
        pop_cnt_q <= (pop_cnt_q == PCW'(NPOP - 1)) ? '0 : pop_cnt_q + 1'b1;
      end
      unique case (state_q)
        ST_IDLE: if (pkt_q != '0) state_q <= ST_INIT;
        ST_INIT: state_q <= ST_LOAD;
        ST_LOAD:
          if (a_done_xfer) begin
            if (slice_q == SW'(LINE_SLICES - 1)) begin
              slice_q <= '0;
              state_q <= ST_WAIT_CALC;
            end else begin
              slice_q <= slice_q + 1'b1;
            end
          end
        ST_WAIT_CALC:
          if (i_calc_done) begin
            grant_q <= UNIT_NUM'(1);
            state_q <= ST_FETCH;
          end
        ST_FETCH:
          if (pop_ok && pop_cnt_q == PCW'(NPOP - 1)) begin
            grant_q <= '0;
            state_q <= ST_DRAIN;
          end
        ST_DRAIN:
          if (ob_cnt_q == '0 && !v1_q) begin
            tile_q  <= (tile_q == TW'(OUT_TILES - 1)) ? '0 : tile_q + 1'b1;
            state_q <= ST_IDLE;
          end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_slave_ctrl_gen.sv
// Scoreboard bench for systolic_slave_ctrl_gen: directed tiles, weights,
// saturation (two instances), backpressure, overflow and reset.
module tb_systolic_slave_ctrl_gen;
  localparam int DW = 64, U = 16, TS = 4, LW = 20, BW = 16;
  localparam int OT = 24, PW = TS * LW, BAW = $clog2(OT * U);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, mst_valid, mst_done, w_avail, w_ready, a_ready;
  logic calc_done, psum_ready;
  logic [DW-1:0] mst_data, w_data;
  logic [PW-1:0] psum;
  logic [BW-1:0] bias;

  logic o_mst_ready, o_w_valid, o_w_done, o_a_valid, o_a_done, o_init;
  logic o_pop, o_pv, o_busy;
  logic [DW-1:0] o_w_data, o_a_data;
  logic [U-1:0] o_grant;
  logic [BAW-1:0] o_baddr;
  logic [PW-1:0] o_pdata;
  logic z_mst_ready, z_w_valid, z_w_done, z_a_valid, z_a_done, z_init;
  logic z_pop, z_pv, z_busy;
  logic [DW-1:0] z_w_data, z_a_data;
  logic [U-1:0] z_grant;
  logic [BAW-1:0] z_baddr;
  logic [PW-1:0] z_pdata;

  systolic_slave_ctrl_gen dut (
    .s_clk(clk), .s_rst(rst),
    .i_mst_valid(mst_valid), .i_mst_data(mst_data), .i_mst_done(mst_done),
    .o_mst_ready(o_mst_ready),
    .i_w_data(w_data), .i_w_avail(w_avail), .o_w_valid(o_w_valid),
    .o_w_data(o_w_data), .o_w_done(o_w_done), .i_w_ready(w_ready),
    .o_a_valid(o_a_valid), .o_a_data(o_a_data), .o_a_done(o_a_done),
    .i_a_ready(a_ready), .o_init(o_init), .i_calc_done(calc_done),
    .o_grant(o_grant), .o_pop(o_pop), .i_psum(psum),
    .o_bias_addr(o_baddr), .i_bias(bias),
    .o_psum_valid(o_pv), .o_psum_data(o_pdata),
    .i_psum_ready(psum_ready), .o_busy(o_busy)
  );

  systolic_slave_ctrl_gen #(.SATURATE(0)) dut0 (
    .s_clk(clk), .s_rst(rst),
    .i_mst_valid(mst_valid), .i_mst_data(mst_data), .i_mst_done(mst_done),
    .o_mst_ready(z_mst_ready),
    .i_w_data(w_data), .i_w_avail(w_avail), .o_w_valid(z_w_valid),
    .o_w_data(z_w_data), .o_w_done(z_w_done), .i_w_ready(w_ready),
    .o_a_valid(z_a_valid), .o_a_data(z_a_data), .o_a_done(z_a_done),
    .i_a_ready(a_ready), .o_init(z_init), .i_calc_done(calc_done),
    .o_grant(z_grant), .o_pop(z_pop), .i_psum(psum),
    .o_bias_addr(z_baddr), .i_bias(bias),
    .o_psum_valid(z_pv), .o_psum_data(z_pdata),
    .i_psum_ready(psum_ready), .o_busy(z_busy)
  );

  int n_vec = 0, n_err = 0, cyc = 0;
  int t_cur = 0, pop_i = 0, pops_tot = 0, outs_tot = 0;
  int adone_cnt = 0, init_cnt = 0, first_cyc = 0, last_cyc = 0;
  int p, ea, b;
  int lv[4], es[4], ew[4];
  logic calc_given = 1'b0, rnd_mode = 1'b0, nxt_pend = 1'b0;
  logic stall_q = 1'b0;
  logic [PW-1:0] held, nxt_psum;
  logic [BW-1:0] nxt_bias;
  logic [DW:0] e_beat;
  logic [PW-1:0] e_word;
  logic [DW:0] sq[$];
  logic [DW:0] wq[$];
  logic [PW-1:0] eq_sat[$];
  logic [PW-1:0] eq_wrap[$];

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] pack4(input int a, input int b2,
                                          input int c, input int d);
    logic [LW-1:0] la, lb, lc, ld;
    la = a[LW-1:0];
    lb = b2[LW-1:0];
    lc = c[LW-1:0];
    ld = d[LW-1:0];
    return {ld, lc, lb, la};
  endfunction

  function automatic int bias_of(input int addr);
    if (addr >= 16 && addr < 32) return 20;
    if (addr >= 32 && addr < 48) return -10;
    return -5;
  endfunction

  task automatic chk_rst();
    chk("rst_mst_ready", o_mst_ready, 1);
    chk("rst_w_valid", o_w_valid, 0);
    chk("rst_w_done", o_w_done, 0);
    chk("rst_a_valid", o_a_valid, 0);
    chk("rst_a_data", {o_a_done, o_a_data}, 0);
    chk("rst_init", o_init, 0);
    chk("rst_grant", o_grant, 0);
    chk("rst_pop", o_pop, 0);
    chk("rst_bias_addr", o_baddr, 0);
    chk("rst_psum_valid", o_pv, 0);
    chk("rst_psum_data", o_pdata, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_err_ovf", dut.err_ovf_q, 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    psum_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    if (nxt_pend) begin
      psum = nxt_psum;
      bias = nxt_bias;
    end
  end

  // Monitor: every expectation is popped when the DUT presents a transfer.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      stall_q  = 1'b0;
      nxt_pend = 1'b0;
    end else begin
      if (o_a_valid && a_ready) begin
        if (sq.size() == 0) chk("spike_unexpected", o_a_data, 0);
        else begin
          e_beat = sq.pop_front();
          chk("spike_beat", {o_a_done, o_a_data}, e_beat);
        end
        if (o_a_done) adone_cnt++;
      end
      if (o_w_valid) begin
        if (wq.size() == 0) chk("weight_unexpected", o_w_data, 0);
        else begin
          e_beat = wq.pop_front();
          chk("weight_beat", {o_w_done, o_w_data}, e_beat);
        end
      end
      if (o_init) init_cnt++;
      nxt_pend = o_pop;
      if (o_pop) begin
        p  = pop_i;
        ea = (t_cur % OT) * U + p % U;
        b  = bias_of(ea);
        chk("grant", o_grant, 1 << (p % U));
        chk("bias_addr", o_baddr, ea);
        chk("pop_after_calc", calc_given, 1);
        if (t_cur == 0) begin
          for (int i = 0; i < 4; i++) begin
            lv[i] = 100; es[i] = 95; ew[i] = 95;
          end
        end else if (t_cur == 1) begin
          for (int i = 0; i < 4; i++) begin
            lv[i] = 524278; es[i] = 524287; ew[i] = -524278;
          end
        end else if (t_cur == 2) begin
          for (int i = 0; i < 4; i++) begin
            lv[i] = -524283; es[i] = -524288; ew[i] = 524283;
          end
        end else begin
          lv[0] = p; lv[1] = -p; lv[2] = 1000 - t_cur; lv[3] = 3 * t_cur;
          for (int i = 0; i < 4; i++) begin
            es[i] = lv[i] + b; ew[i] = es[i];
          end
        end
        nxt_psum = pack4(lv[0], lv[1], lv[2], lv[3]);
        nxt_bias = b[BW-1:0];
        eq_sat.push_back(pack4(es[0], es[1], es[2], es[3]));
        eq_wrap.push_back(pack4(ew[0], ew[1], ew[2], ew[3]));
        pop_i++;
        pops_tot++;
      end
      if (stall_q) begin
        chk("hold_valid", o_pv, 1);
        chk("hold_data", o_pdata, held);
      end
      if (o_pv && psum_ready) begin
        if (eq_sat.size() == 0) chk("psum_unexpected", o_pdata, 0);
        else begin
          e_word = eq_sat.pop_front();
          chk("psum_sat", o_pdata, e_word);
        end
        if (t_cur == 0 && outs_tot == 0) first_cyc = cyc;
        if (t_cur == 0 && outs_tot == 255) last_cyc = cyc;
        outs_tot++;
      end
      if (z_pv && psum_ready) begin
        if (eq_wrap.size() == 0) chk("psum_wrap_unexpected", z_pdata, 0);
        else begin
          e_word = eq_wrap.pop_front();
          chk("psum_wrap", z_pdata, e_word);
        end
      end
      stall_q = o_pv && !psum_ready;
      held    = o_pdata;
      if (o_busy) chk("outstanding_le4", (pops_tot - outs_tot) <= 4, 1);
    end
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    int n;
    int a_base;
    rst = 1'b1;
    mst_valid = 0; mst_done = 0; mst_data = '0;
    w_avail = 0; w_ready = 0; w_data = '0;
    a_ready = 1; calc_done = 0; psum = '0; bias = '0;
    psum_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_rst();
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < 64; k++) begin
      @(posedge clk); #1;
      w_avail = 1; w_ready = 1;
      w_data = 64'(k) + 64'h1000;
      wq.push_back({(k % 32 == 31), w_data});
    end
    @(posedge clk); #1;
    w_ready = 0;
    @(posedge clk); #1;
    w_avail = 0;
    @(negedge clk);
    chk("weight_beats_left", wq.size(), 0);

    for (int t = 0; t < 25; t++) begin
      t_cur = t; pop_i = 0; calc_given = 0;
      a_base = adone_cnt;
      rnd_mode = (t >= 3);
      if (t == 3) begin
        @(posedge clk); #1;
        calc_done = 1;
        @(posedge clk); #1;
        calc_done = 0;
      end
      for (int k = 0; k < 24; k++) begin
        @(posedge clk); #1;
        mst_valid = 1; mst_done = 1;
        mst_data = 64'(t * 1000 + k);
        calc_done = (t == 3 && k == 12);
        sq.push_back({1'b1, mst_data});
      end
      @(posedge clk); #1;
      mst_valid = 0; mst_done = 0; calc_done = 0;
      n = 0;
      while (adone_cnt - a_base < 24 && n < 500) begin
        @(negedge clk); n++;
      end
      chk("a_done_per_tile", adone_cnt - a_base, 24);
      repeat (2) @(negedge clk);
      chk("a_valid_in_wait", o_a_valid, 0);
      chk("no_pop_before_calc", pop_i, 0);
      @(posedge clk); #1;
      calc_done = 1; calc_given = 1;
      @(posedge clk); #1;
      calc_done = 0;
      n = 0;
      while (!(pop_i == 256 && outs_tot == 256 * (t + 1) && !o_busy)
             && n < 5000) begin
        @(negedge clk); n++;
      end
      chk("tile_pops", pop_i, 256);
      chk("tile_outs", outs_tot, 256 * (t + 1));
      chk("tile_idle", o_busy, 0);
      chk("init_pulses", init_cnt, t + 1);
      if (t == 0) chk("throughput_span", last_cyc - first_cyc, 255);
    end
    chk("sat_queue_empty", eq_sat.size(), 0);
    chk("wrap_queue_empty", eq_wrap.size(), 0);

    rnd_mode = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 65; k++) begin
      mst_valid = 1; mst_done = 0;
      mst_data = 64'(k) + 64'h5000;
      @(posedge clk);
      @(negedge clk);
      if (k == 61) chk("ready_at_62", o_mst_ready, 1);
      if (k == 62) chk("ready_at_63", o_mst_ready, 0);
      if (k == 63) chk("ovf_at_full", dut.err_ovf_q, 0);
      if (k == 64) chk("ovf_after_drop", dut.err_ovf_q, 1);
    end
    mst_valid = 0;
    @(negedge clk);
    chk("idle_no_packet", o_busy, 0);

    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk_rst();

    @(posedge clk); #1;
    mst_valid = 1; mst_done = 1; mst_data = 64'hABCD;
    sq.push_back({1'b1, mst_data});
    @(posedge clk); #1;
    mst_valid = 0; mst_done = 0;
    n = 0;
    while (sq.size() != 0 && n < 50) begin
      @(negedge clk); n++;
    end
    chk("flush_first_beat", sq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/systolic_slave_ctrl_gen.md
Name: systolic_slave_ctrl_gen

Overview:
Parametrised slave-side controller for one systolic array (linear K/V/Q class). It forwards weight beats with a beat-counted done, buffers spike-slice packets from the master controller, and sequences one full line of slices into the array. After compute it drains the partial-sum FIFOs using one-hot grant rotation. Each drained psum gets a per-channel bias added per time-step lane, with optional saturation, and is sent out under a valid/ready handshake with backpressure.

Parameters:
DATA_WIDTH, 64, spike/weight beat width
UNIT_NUM, 16, systolic array dimension; psum words per tile = UNIT_NUM*UNIT_NUM
TIME_STEPS, 4, lanes per psum word
LANE_WIDTH, 20, bits per lane; psum width = TIME_STEPS*LANE_WIDTH
BIAS_WIDTH, 16, signed bias width (must be <= LANE_WIDTH)
LINE_SLICES, 24, spike packets per line before fetch
OUT_TILES, 24, output-channel tiles; bias address wraps after OUT_TILES*UNIT_NUM
W_BEATS, 32, weight beats per weight slice
PKT_FIFO_DEPTH, 64, internal spike FIFO depth (power of 2)
SATURATE, 1, 1 = clamp lanes to signed LANE_WIDTH range, 0 = wrap

Ports:
s_clk  in  1  clock
s_rst  in  1  synchronous active-high reset
i_mst_valid  in  1  spike beat from master
i_mst_data  in  DATA_WIDTH  spike beat
i_mst_done  in  1  last beat of packet (qualified by i_mst_valid)
o_mst_ready  out  1  FIFO not almost-full (>=2 free entries)
i_w_data  in  DATA_WIDTH  weight FIFO data
i_w_avail  in  1  weight FIFO non-empty
o_w_valid  out  1  weight beat valid, also the weight FIFO pop
o_w_data  out  DATA_WIDTH  equals i_w_data
o_w_done  out  1  last weight beat of slice
i_w_ready  in  1  array accepts weight
o_a_valid  out  1  spike beat to array
o_a_data  out  DATA_WIDTH  spike beat
o_a_done  out  1  last beat of packet
i_a_ready  in  1  array accepts spike
o_init  out  1  array prepare pulse
i_calc_done  in  1  array finished tile compute
o_grant  out  UNIT_NUM  one-hot psum FIFO select
o_pop  out  1  psum FIFO read strobe
i_psum  in  TIME_STEPS*LANE_WIDTH  psum FIFO data, 1-cycle read latency
o_bias_addr  out  clog2(OUT_TILES*UNIT_NUM)  bias memory address
i_bias  in  BIAS_WIDTH  signed bias, 1-cycle read latency
o_psum_valid  out  1  output valid
o_psum_data  out  TIME_STEPS*LANE_WIDTH  biased psum
i_psum_ready  in  1  downstream ready
o_busy  out  1  state != IDLE

Behaviour:
- Reset: every output 0 except o_mst_ready=1. FIFO, counters, tile index = 0. State = IDLE.
- FSM states: IDLE, INIT, LOAD, WAIT_CALC, FETCH, DRAIN.
  - IDLE -> INIT when the FIFO holds at least one complete packet. INIT lasts 1 cycle and asserts o_init.
  - INIT -> LOAD.
  - LOAD -> WAIT_CALC on the accepted o_a_done when slice_cnt == LINE_SLICES-1.
  - WAIT_CALC -> FETCH on i_calc_done.
  - FETCH -> DRAIN after UNIT_NUM*UNIT_NUM pops.
  - DRAIN -> IDLE when the output buffer is empty and nothing is in flight. The tile index increments here, wrapping at OUT_TILES-1 -> 0.
- Spike path:
  - FIFO entry = {done, data}. A complete-packet counter increments on a written done and decrements on an accepted o_a_done; if both happen in the same cycle it is unchanged.
  - In LOAD, o_a_valid = FIFO non-empty and a complete packet is present. A beat transfers on o_a_valid & i_a_ready.
  - A write while full is dropped and sets sticky internal err_ovf (bench-visible).
- Weight path:
  - o_w_valid = i_w_avail & i_w_ready, in any state.
  - Beat counter increments per transfer. o_w_done is asserted combinationally with beat W_BEATS-1, then the counter clears.
- Fetch:
  - On FETCH entry, o_grant = 1 (bit 0).
  - A pop is issued only when the in-flight count plus the occupancy of the 4-entry output buffer is < 4. Each pop rotates o_grant left by 1.
  - o_bias_addr = tile*UNIT_NUM + (pop_idx mod UNIT_NUM), presented in the same cycle as o_pop.
- Bias add (registered):
  - Each lane = sign-extended lane of i_psum + sign-extended i_bias, computed in LANE_WIDTH+1 bits.
  - SATURATE=1: clamp to [-2^(LANE_WIDTH-1), 2^(LANE_WIDTH-1)-1]. SATURATE=0: truncate.
  - Pop-to-buffer latency is 2 cycles; the result then enters the output buffer.
- Output:
  - Data and valid hold stable while o_psum_valid & ~i_psum_ready.
  - Order equals pop order.
  - With i_psum_ready held high, throughput is 1 word/cycle.
- i_calc_done outside WAIT_CALC is ignored.
- Mid-operation reset flushes the FIFO, pipeline and output buffer within the reset cycle.

Test Plan:
- Default params: 24 single-beat packets, i_a_ready=1, then i_calc_done. Required: o_init pulses once; exactly 24 o_a_done; 256 o_pop; grant sequence 1,2,4,...,0x8000,1,...; 256 outputs.
- Psum lanes all 100, bias=-5 at every address. Required: every output lane = 95. Over 24 tiles, o_bias_addr spans 0..383 and then returns to 0.
- Lane value 2^19-10 with bias 20, SATURATE=1. Required: lane = 2^19-1. With SATURATE=0: lane = -2^19+10.
- i_psum_ready toggled 1/0 at random during FETCH. Required: no output lost or duplicated; data stable while stalled; in-flight plus buffer never > 4.
- Weight FIFO stream of 64 beats with i_w_ready=1. Required: o_w_done on beats 31 and 63 only.
- Fill the FIFO to full (64 entries) and write again. Required: err_ovf=1; o_mst_ready=0 at 63 entries. Then assert s_rst for 1 cycle. Required: all outputs return to reset values.
